// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_controller
// Brief    : Binary-to-BCD (double dabble) converter with a display register
//            and a programmable-rate four-digit scan for an FND select decoder.
// Revision : 1.0
// ============================================================================
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000,
  parameter int DATA_W   = 14
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_load,
  input  logic              i_blank_lz,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [1:0]        o_digitSelect,
  output logic              o_en,
  output logic [3:0]        o_bcd
);

  localparam int              c_PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
  localparam int              c_IW        = $clog2(DATA_W + 1);
  localparam logic [c_IW-1:0] c_LAST_ITER = c_IW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_bin;
  logic [15:0]       r_acc;
  logic [c_IW-1:0]   r_iter;
  logic              r_busy;
  logic              r_overflow;
  logic [15:0]       r_disp;
  logic [c_PW-1:0]   r_presc;
  logic [1:0]        r_digit;

  logic [15:0]       w_adj;
  logic              w_over;
  logic              w_lz1;
  logic              w_lz2;
  logic              w_lz3;

  assign w_over = (32'(i_value) > 32'd9999);

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < 4; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_iter     <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_disp     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_bin      <= w_over ? DATA_W'(9999) : i_value;
            r_overflow <= w_over;
            r_acc      <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc  <= {w_adj[14:0], r_bin[DATA_W-1]};
          r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
          r_iter <= r_iter + 1'b1;
          if (r_iter == c_LAST_ITER) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_disp  <= r_acc;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (r_presc == c_PRESC_MAX) begin
      r_presc <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_lz3 = (r_disp[15:12] == 4'd0);
  assign w_lz2 = w_lz3 && (r_disp[11:8] == 4'd0);
  assign w_lz1 = w_lz2 && (r_disp[7:4] == 4'd0);

  always_comb begin
    o_bcd = r_disp[3:0];
    o_en  = 1'b1;
    case (r_digit)
      2'd0: o_bcd = r_disp[3:0];
      2'd1: begin
        o_bcd = r_disp[7:4];
        o_en  = !(i_blank_lz && w_lz1);
      end
      2'd2: begin
        o_bcd = r_disp[11:8];
        o_en  = !(i_blank_lz && w_lz2);
      end
      default: begin
        o_bcd = r_disp[15:12];
        o_en  = !(i_blank_lz && w_lz3);
      end
    endcase
  end

  assign o_busy        = r_busy;
  assign o_overflow    = r_overflow;
  assign o_digitSelect = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_controller
// Brief    : Randomized and directed bench against a decimal reference model.
// Revision : 1.0
// ============================================================================
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int DATA_W   = 14;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] r_value;
  logic              r_load;
  logic              r_blank;
  logic              w_busy;
  logic              w_overflow;
  logic [1:0]        w_sel;
  logic              w_en;
  logic [3:0]        w_bcd;

  int errors = 0;
  int checks = 0;

  // Reference model: edges since reset release, pending display value and
  // the edge on which it becomes visible.
  int e;
  int done_edge;
  int m_disp;
  int m_pend;
  int m_ovf;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .DATA_W(DATA_W)) u_dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_value       (r_value),
    .i_load        (r_load),
    .i_blank_lz    (r_blank),
    .o_busy        (w_busy),
    .o_overflow    (w_overflow),
    .o_digitSelect (w_sel),
    .o_en          (w_en),
    .o_bcd         (w_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, e, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  task automatic model_reset();
    e         = 0;
    done_edge = -100;
    m_disp    = 0;
    m_pend    = 0;
    m_ovf     = 0;
  endtask

  task automatic compare_outputs();
    int slot;
    int exp_en;
    slot   = (e / SCAN_DIV) % 4;
    exp_en = (r_blank && slot != 0 && m_disp < pow10(slot)) ? 0 : 1;
    check("sel",  int'(w_sel),      slot);
    check("bcd",  int'(w_bcd),      (m_disp / pow10(slot)) % 10);
    check("en",   int'(w_en),       exp_en);
    check("busy", int'(w_busy),     (e < done_edge) ? 1 : 0);
    check("ovf",  int'(w_overflow), m_ovf);
  endtask

  task automatic step();
    int v;
    @(posedge clk);
    e++;
    if (r_load && e > done_edge) begin
      v         = int'(r_value);
      m_ovf     = (v > 9999) ? 1 : 0;
      m_pend    = (v > 9999) ? 9999 : v;
      done_edge = e + 15;
    end
    if (e == done_edge) m_disp = m_pend;
    #1;
    compare_outputs();
  endtask

  task automatic load(input int v);
    r_value = DATA_W'(v);
    r_load  = 1'b1;
    step();
    r_load  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int busy_cnt;
    rst_n   = 1'b0;
    r_value = '0;
    r_load  = 1'b0;
    r_blank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_outputs();
    run(20);

    // Conversion latency and digit order
    load(1234);
    busy_cnt = int'(w_busy);
    for (int i = 0; i < 20; i++) begin
      step();
      busy_cnt += int'(w_busy);
    end
    check("busy_len", busy_cnt, 15);
    run(16);

    load(12000);
    run(32);
    load(5);
    run(32);

    // Leading-zero blanking
    r_blank = 1'b1;
    load(42);
    run(32);
    r_blank = 1'b0;
    run(16);
    r_blank = 1'b1;
    load(0);
    run(32);
    r_blank = 1'b0;

    // Load while busy is ignored
    load(1234);
    run(2);
    load(5678);
    run(30);

    // Reset in the middle of a conversion
    load(777);
    run(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(w_busy),     0);
    check("rst_sel",  int'(w_sel),      0);
    check("rst_bcd",  int'(w_bcd),      0);
    check("rst_ovf",  int'(w_overflow), 0);
    check("rst_en",   int'(w_en),       1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare_outputs();
    run(20);

    // Display update coincides with the digit-counter wrap
    for (int i = 0; i < 16 && (e % 16) != 0; i++) step();
    load(9999);
    run(40);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r_value = DATA_W'($urandom_range(0, 16383));
      r_load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) r_blank = ~r_blank;
      step();
    end
    r_load = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
